// File: rtl/jtopl_wrqueue.sv
// jtopl_wrqueue
//   Host-side write queue in front of an OPL/OPL2/OPL3 core. Host register
//   writes are captured at full clk rate with no wait states. Each queued write
//   is then replayed to the core bus as an address write followed by a data
//   write, with the chip's recovery delays counted in cen ticks.
//
// Ports
//   rst        in   synchronous reset, active high
//   clk        in   single clock for all logic
//   cen        in   clock enable for dispatch timing
//   din        in   [7:0]    host write data
//   addr       in   [AW-1:0] host address: bit0 0=index port 1=data port,
//                            upper bits select the register bank
//   cs_n       in   host chip select, active low
//   wr_n       in   host write strobe, active low
//   chip_din   out  [7:0]    data to core
//   chip_addr  out  [AW-1:0] address to core
//   chip_cs_n  out  core chip select, active low
//   chip_wr_n  out  core write strobe, active low
//   full       out  queue holds DEPTH entries
//   empty      out  queue empty and dispatcher idle
//   ovf        out  sticky: a data write was dropped because the queue was full
module jtopl_wrqueue #(
  parameter int DEPTH     = 16,
  parameter int AW        = 1,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic [7:0]    din,
  input  logic [AW-1:0] addr,
  input  logic          cs_n,
  input  logic          wr_n,
  output logic [7:0]    chip_din,
  output logic [AW-1:0] chip_addr,
  output logic          chip_cs_n,
  output logic          chip_wr_n,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int NB   = 1 << (AW - 1);
  localparam int BW   = (AW > 1) ? AW - 1 : 1;
  localparam int EW   = AW - 1 + 16;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int WW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AWAIT,
    S_DATA,
    S_DWAIT
  } state_t;

  // Host capture state
  logic            r_hw_q;
  logic [7:0]      r_idx [NB];
  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovf;

  // Dispatcher state
  state_t          r_state;
  logic [WW-1:0]   r_wcnt;
  logic [EW-1:0]   r_hold;
  logic [7:0]      r_chip_din;
  logic [AW-1:0]   r_chip_addr;
  logic            r_chip_cs_n;
  logic            r_chip_wr_n;

  logic            w_hw;
  logic            w_evt;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic [BW-1:0]   w_bank;
  logic [EW-1:0]   w_entry;
  logic [AW-1:0]   w_addr_a;
  logic [AW-1:0]   w_addr_d;

  // A held strobe yields a single event: only the rising edge of hw counts.
  assign w_hw       = ~cs_n & ~wr_n;
  assign w_evt      = w_hw & ~r_hw_q;
  assign w_push_req = w_evt & addr[0];
  assign w_pop      = (r_state == S_IDLE) && (r_cnt != '0);
  // A pop in the same cycle frees a slot, so a push into a full queue still fits.
  assign w_push     = w_push_req & (~full | w_pop);

  assign full  = (r_cnt == CNTW'(DEPTH));
  assign empty = (r_cnt == '0) && (r_state == S_IDLE);
  assign ovf   = r_ovf;

  assign chip_din  = r_chip_din;
  assign chip_addr = r_chip_addr;
  assign chip_cs_n = r_chip_cs_n;
  assign chip_wr_n = r_chip_wr_n;

  // Entry layout: {bank, index, data}; the bank field only exists when AW > 1.
  generate
    if (AW > 1) begin : g_banked
      assign w_bank   = addr[AW-1:1];
      assign w_entry  = {w_bank, r_idx[w_bank], din};
      assign w_addr_a = {r_hold[EW-1:16], 1'b0};
      assign w_addr_d = {r_hold[EW-1:16], 1'b1};
    end else begin : g_single
      assign w_bank   = 1'b0;
      assign w_entry  = {r_idx[w_bank], din};
      assign w_addr_a = 1'b0;
      assign w_addr_d = 1'b1;
    end
  endgenerate

  // Host capture: index latches, queue pointers, occupancy, overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hw_q <= 1'b0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < NB; i++) r_idx[i] <= '0;
    end else begin
      r_hw_q <= w_hw;
      if (w_evt && !addr[0]) r_idx[w_bank] <= din;
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      if (w_push_req && !w_push) r_ovf <= 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNTW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNTW'(1);
    end
  end

  // Queue storage and hold register carry data only
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_entry;
    if (w_pop)  r_hold      <= r_mem[r_rp];
  end

  // Dispatcher. In S_ADDR the strobe register doubles as the phase bit:
  // first cen tick asserts, second releases. AWAIT exits straight into an
  // asserted data strobe so the address-to-data gap is exactly ADDR_WAIT idle ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_chip_din  <= '0;
      r_chip_addr <= '0;
      r_chip_cs_n <= 1'b1;
      r_chip_wr_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_ADDR;
        end
        S_ADDR: begin
          if (cen) begin
            if (r_chip_wr_n) begin
              r_chip_addr <= w_addr_a;
              r_chip_din  <= r_hold[15:8];
              r_chip_cs_n <= 1'b0;
              r_chip_wr_n <= 1'b0;
            end else begin
              r_chip_cs_n <= 1'b1;
              r_chip_wr_n <= 1'b1;
              r_wcnt      <= WW'(ADDR_WAIT - 1);
              r_state     <= S_AWAIT;
            end
          end
        end
        S_AWAIT: begin
          if (cen) begin
            if (r_wcnt == '0) begin
              r_chip_addr <= w_addr_d;
              r_chip_din  <= r_hold[7:0];
              r_chip_cs_n <= 1'b0;
              r_chip_wr_n <= 1'b0;
              r_state     <= S_DATA;
            end else begin
              r_wcnt <= r_wcnt - WW'(1);
            end
          end
        end
        S_DATA: begin
          if (cen) begin
            r_chip_cs_n <= 1'b1;
            r_chip_wr_n <= 1'b1;
            r_wcnt      <= WW'(DATA_WAIT - 1);
            r_state     <= S_DWAIT;
          end
        end
        S_DWAIT: begin
          if (cen) begin
            if (r_wcnt == '0) r_state <= S_IDLE;
            else              r_wcnt  <= r_wcnt - WW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrqueue.sv
// Testbench for jtopl_wrqueue: directed scenarios plus randomized host write
// bursts, checked against a queue-level reference model of the write stream.
module tb_jtopl_wrqueue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int A_W   = 12;
  localparam int D_W   = 84;

  logic          clk;
  logic          rst;
  logic          cen;
  logic [7:0]    din;
  logic [AW-1:0] addr;
  logic          cs_n;
  logic          wr_n;
  logic [7:0]    chip_din;
  logic [AW-1:0] chip_addr;
  logic          chip_cs_n;
  logic          chip_wr_n;
  logic          full;
  logic          empty;
  logic          ovf;

  jtopl_wrqueue #(
    .DEPTH(DEPTH), .AW(AW), .ADDR_WAIT(A_W), .DATA_WAIT(D_W)
  ) dut (
    .rst(rst), .clk(clk), .cen(cen), .din(din), .addr(addr),
    .cs_n(cs_n), .wr_n(wr_n), .chip_din(chip_din), .chip_addr(chip_addr),
    .chip_cs_n(chip_cs_n), .chip_wr_n(chip_wr_n), .full(full),
    .empty(empty), .ovf(ovf)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  // Reference model: expected core write stream and queue occupancy
  wr_t        exp_q[$];
  logic [7:0] m_idx [2];
  int         pend_n  = 0;
  bit         m_ovf   = 0;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int cen_per = 1;
  int n_wr    = 0;
  int last_addr = 0;
  int last_data = -1;
  bit b2b     = 0;
  int ev_cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // cen: constant high, or one pulse every cen_per clocks
  initial begin
    cen = 1'b1;
    forever begin
      @(negedge clk);
      cen = (cen_per == 1) || ((cyc % cen_per) == cen_per - 1);
    end
  end

  // Core bus monitor
  initial begin
    bit  prev_act;
    bit  act;
    int  start;
    wr_t e;
    prev_act = 1'b0;
    start    = 0;
    forever begin
      @(negedge clk);
      act = !chip_cs_n && !chip_wr_n;
      if (act && !prev_act) begin
        start = cyc;
        n_wr++;
        chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(chip_addr), 32'(e.a));
          chk("wr_data", 32'(chip_din), 32'(e.d));
        end
        if (chip_addr[0] == 1'b0) begin
          pend_n--;
          if (last_data >= 0) begin
            if (b2b && cen_per == 1) chk("d2a_gap", cyc - last_data, D_W + 3);
            else chk("d2a_min", 32'((cyc - last_data) >= (D_W + 1) * cen_per), 32'd1);
          end
          last_addr = cyc;
        end else begin
          chk("a2d_gap", cyc - last_addr, (A_W + 1) * cen_per);
          last_data = cyc;
          b2b = (pend_n > 0);
        end
      end
      if (!act && prev_act) chk("pulse_len", cyc - start, cen_per);
      prev_act = act;
    end
  end

  // One host write event; the model is updated as the event is issued.
  task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d,
                         input int hold, input int gap);
    wr_t w;
    addr = a;
    din  = d;
    cs_n = 1'b0;
    wr_n = 1'b0;
    ev_cyc = cyc + 1;
    if (a[0] == 1'b0) begin
      m_idx[a[AW-1]] = d;
    end else if (pend_n < DEPTH) begin
      w.a = {a[AW-1], 1'b0};
      w.d = m_idx[a[AW-1]];
      exp_q.push_back(w);
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
      pend_n++;
    end else begin
      m_ovf = 1'b1;
    end
    repeat (hold) @(negedge clk);
    if ($urandom_range(0, 1) == 1) cs_n = 1'b1;
    else                           wr_n = 1'b1;
    din = 8'($urandom);
    repeat (gap) @(negedge clk);
    cs_n = 1'b1;
    wr_n = 1'b1;
  endtask

  task automatic wait_empty(input int limit);
    int n;
    n = 0;
    while (empty !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("empty_timeout", 32'(n < limit), 32'd1);
    chk("leftover_writes", exp_q.size(), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_n    = 0;
    m_ovf     = 1'b0;
    m_idx[0]  = 8'h00;
    m_idx[1]  = 8'h00;
    last_data = -1;
    b2b       = 1'b0;
  endtask

  initial begin
    int t;
    int n0;
    int nev;
    rst  = 1'b1;
    cs_n = 1'b1;
    wr_n = 1'b1;
    din  = 8'h00;
    addr = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cs_n",  32'(chip_cs_n), 32'd1);
    chk("rst_wr_n",  32'(chip_wr_n), 32'd1);
    chk("rst_din",   32'(chip_din),  32'd0);
    chk("rst_addr",  32'(chip_addr), 32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_empty", 32'(empty),     32'd1);
    chk("rst_ovf",   32'(ovf),       32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write with exact latency, cen constant high
    host_wr(2'd0, 8'h20, 1, 2);
    host_wr(2'd1, 8'h01, 1, 2);
    t = ev_cyc;
    while (cyc < t + A_W + D_W + 3) @(negedge clk);
    chk("empty_in_dwait", 32'(empty), 32'd0);
    @(negedge clk);
    chk("empty_at_idle", 32'(empty), 32'd1);
    chk("lat_addr", last_addr, t + 2);
    chk("lat_data", last_data, t + 3 + A_W);
    chk("single_leftover", exp_q.size(), 0);

    // Bank select
    host_wr(2'd0, 8'h05, 1, 1);
    host_wr(2'd2, 8'h05, 1, 1);
    host_wr(2'd3, 8'hAA, 1, 1);
    host_wr(2'd1, 8'h55, 1, 1);
    wait_empty(2000);

    // Held strobe gives one entry
    n0 = n_wr;
    host_wr(2'd1, 8'h3C, 10, 2);
    wait_empty(1000);
    chk("held_one_entry", n_wr - n0, 2);

    // Burst and overflow
    chk("pre_burst_ovf", 32'(ovf), 32'(m_ovf));
    for (int k = 0; k < 6; k++) host_wr(2'd1, 8'(8'h90 + k), 1, 1);
    chk("burst_full", 32'(full), 32'(pend_n == DEPTH));
    chk("burst_ovf",  32'(ovf),  32'(m_ovf));
    wait_empty(3000);
    chk("drain_full", 32'(full), 32'd0);

    // Sparse cen
    cen_per   = 4;
    last_data = -1;
    host_wr(2'd2, 8'h41, 1, 1);
    host_wr(2'd3, 8'h42, 1, 1);
    host_wr(2'd3, 8'h43, 2, 1);
    wait_empty(6000);

    // Randomized bursts, each starting from an idle dispatcher
    for (int b = 0; b < 8; b++) begin
      cen_per   = ($urandom_range(0, 1) == 1) ? 4 : 1;
      last_data = -1;
      b2b       = 1'b0;
      nev       = $urandom_range(2, 9);
      for (int k = 0; k < nev; k++)
        host_wr(AW'($urandom_range(0, 3)), 8'($urandom),
                $urandom_range(1, 3), $urandom_range(1, 3));
      chk("rnd_full", 32'(full), 32'(pend_n == DEPTH));
      chk("rnd_ovf",  32'(ovf),  32'(m_ovf));
      wait_empty(6000);
    end

    // Reset during AWAIT with the queue full behind the in-flight entry
    cen_per   = 1;
    last_data = -1;
    host_wr(2'd0, 8'h11, 1, 1);
    for (int k = 0; k < 5; k++) host_wr(2'd1, 8'(8'hC0 + k), 1, 1);
    chk("pre_rst_full", 32'(full), 32'(pend_n == DEPTH));
    chk("pre_rst_ovf",  32'(ovf),  32'(m_ovf));
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_cs_n",  32'(chip_cs_n), 32'd1);
    chk("mid_rst_wr_n",  32'(chip_wr_n), 32'd1);
    chk("mid_rst_empty", 32'(empty),     32'd1);
    chk("mid_rst_full",  32'(full),      32'd0);
    chk("mid_rst_ovf",   32'(ovf),       32'd0);
    rst = 1'b0;
    n0  = n_wr;
    repeat (300) @(negedge clk);
    chk("no_wr_after_rst", n_wr - n0, 0);
    chk("idle_after_rst", 32'(empty), 32'd1);

    // Index latches were cleared by reset
    host_wr(2'd1, 8'h77, 1, 1);
    wait_empty(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtopl_wrqueue.md
Name: jtopl_wrqueue

Overview:
- Parametrised CPU-side write queue in front of the OPL/OPL2/OPL3 cores.
- Absorbs back-to-back host register writes without host wait states.
- Replays each write to the core bus as an address write followed by a data write, with the chip's mandatory inter-write delays counted in cen ticks.
- Generalises the single-bank, 1-bit-address host interface to multiple register banks (OPL3-style) and a configurable queue depth.

Parameters:
- DEPTH, 16: queue entries; power of two, 2..256.
- AW, 1: host and chip address width; 1 = OPL/OPL2, 2 = OPL3 dual bank. Banks NB = 2^(AW-1).
- ADDR_WAIT, 12: cen ticks the core bus stays idle after an address write; must be ≥1.
- DATA_WAIT, 84: cen ticks the core bus stays idle after a data write; must be ≥1.

Ports:
- rst  in  1  synchronous reset, active high
- clk  in  1  single clock for all logic
- cen  in  1  clock enable for dispatch timing
- din  in  8  host write data
- addr  in  AW  host address; bit0 = 0 register-index port, 1 data port; upper bits select bank
- cs_n  in  1  host chip select, active low
- wr_n  in  1  host write strobe, active low
- chip_din  out  8  data to core
- chip_addr  out  AW  address to core
- chip_cs_n  out  1  core chip select
- chip_wr_n  out  1  core write strobe
- full  out  1  queue holds DEPTH entries
- empty  out  1  queue holds 0 entries and dispatcher is idle
- ovf  out  1  sticky: a push was dropped because the queue was full

Behaviour:
- One clock (clk); reset is synchronous and active high (rst). All state updates on the rising edge of clk.
- Reset values:
  - chip_cs_n = 1, chip_wr_n = 1, chip_din = 0, chip_addr = 0.
  - full = 0, empty = 1, ovf = 0.
  - Queue pointers = 0; all bank index latches = 0; FSM = IDLE; wait counter = 0.
  - rst asserted mid-dispatch aborts the current transfer and discards all queued entries. The core strobes go inactive on the next edge.
- Host strobe: hw = !cs_n & !wr_n. A write event is the first clk cycle with hw high after a cycle with hw low. A strobe held for N cycles produces exactly one event. Host capture is not gated by cen.
- Event with addr[0] = 0: idx[addr[AW-1:1]] <= din. No push. (AW = 1: single bank 0.)
- Event with addr[0] = 1: push {bank, idx[bank], din} (AW-1+16 bits).
  - If full, drop the entry and set ovf.
  - ovf clears only on rst.
- Push and pop in the same cycle: both take effect; count unchanged; full is unaffected even when count = DEPTH.
- Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Dispatcher FSM; all transitions except IDLE→ADDR happen only when cen = 1:
  - IDLE: if the queue is not empty, pop the head into the hold register and go to ADDR. The pop is a clk-cycle action, not cen-gated.
  - ADDR: drive chip_addr = {bank, 0}, chip_din = reg, chip_cs_n = 0, chip_wr_n = 0 for exactly one cen tick. Then release the strobes, load cnt = ADDR_WAIT-1, go to AWAIT.
  - AWAIT: decrement cnt per cen tick; at 0 go to DATA.
  - DATA: drive chip_addr = {bank, 1}, chip_din = data, strobes low for one cen tick. Then release, load cnt = DATA_WAIT-1, go to DWAIT.
  - DWAIT: decrement per cen tick; at 0 go to IDLE.
  - Latency with cen = 1 constant: host data event at cycle t → ADDR strobe cycle t+2 → DATA strobe t+3+ADDR_WAIT → next entry eligible t+4+ADDR_WAIT+DATA_WAIT.
- chip_din and chip_addr hold their last driven value while the strobes are inactive.
- empty = (count == 0) && (FSM == IDLE).
- Index-latch write and data push to the same bank never coincide; each is a separate event.
- A new index write while an entry is queued does not affect that entry; the index is captured at push time.

Test Plan:
- Single write, AW=1, cen=1: host idx 0x20 then data 0x01 → ADDR strobe addr=0 din=0x20, 12 cycles idle, DATA strobe addr=1 din=0x01, then 84 idle cycles; empty returns to 1 after DWAIT.
- Burst and overflow, DEPTH=4: push 6 data writes with no gap → full=1 after the 4th accepted entry (one entry may already be in the hold register); dropped writes set ovf=1; replay order and values match the accepted writes exactly.
- Bank select, AW=2: idx0 = 0x05 (addr 0), idx1 = 0x05 (addr 2), data 0xAA to addr 3, data 0x55 to addr 1 → core sees addr 2/0x05, 3/0xAA, then 0/0x05, 1/0x55.
- cen = 1 every 4th clk, ADDR_WAIT=2, DATA_WAIT=3 → strobe pulses last 4 clk; address-to-data spacing is 3 cen ticks; data-to-next-address spacing is 4 cen ticks.
- Held strobe: cs_n and wr_n low for 10 clk on the data port → exactly one entry queued.
- rst pulse during AWAIT with 3 entries queued → next edge strobes high, empty=1, full=0, ovf=0; no further core writes occur.
